// File: rtl/hex_line_sender.sv
// hex_line_sender
//   Captures a binary value and prints it as ASCII hex, most significant
//   nibble first. When ADD_CRLF is set, CR LF follows the digits. The bytes
//   are fed one at a time into a UART transmitter byte interface.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   value        value to print; sampled when a request is accepted
//   value_valid  request to print value
//   value_ready  high while idle; the request is accepted when value_valid is also high
//   tx_busy      UART transmitter is busy with a byte
//   tx_send      byte presented to the UART; holds the last issued byte between strobes
//   tx_ready     one-cycle strobe; the UART latches tx_send
//   busy         high while a line is in progress (~value_ready)
//   overrun      sticky; set by a request that was dropped while busy
//   dbg_state    current FSM state (IDLE=0, ISSUE=1, ACCEPT=2, DRAIN=3)
//
// Handshake: a request is taken at a rising edge where value_valid and
// value_ready are both high. tx_ready is a single-cycle strobe. It is asserted
// only in ISSUE and only while tx_busy is low. The UART samples tx_send in the
// strobe cycle.
module hex_line_sender #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_CRLF   = 1,
    parameter int UPPERCASE  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  tx_busy,
    output logic [7:0]            tx_send,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);

    localparam int NIB = DATA_WIDTH / 4;
    localparam int IW  = $clog2(NIB + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'((ADD_CRLF != 0) ? NIB + 1 : NIB - 1);
    localparam logic [IW-1:0] CR_IDX   = IW'(NIB);
    localparam logic [7:0]    ALPHA    = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_ACCEPT = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [7:0]            send_q, send_d;
    logic                  overrun_q, overrun_d;
    // A request was seen while busy and has not yet been resolved. A pending
    // request becomes an overrun only if it is withdrawn before the block
    // returns to idle. A request held through the end of the line is simply
    // accepted afterwards.
    logic                  pend_q, pend_d;

    logic [3:0]            nib;
    logic [7:0]            char_cur;

    // Select the nibble for the current character index.
    always_comb begin
        nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                nib = hold_q[DATA_WIDTH-1-4*i -: 4];
            end
        end
    end

    always_comb begin
        char_cur = 8'h00;
        if (idx_q < CR_IDX) begin
            if (nib < 4'd10) begin
                char_cur = 8'h30 + {4'h0, nib};
            end else begin
                char_cur = ALPHA + {4'h0, nib} - 8'd10;
            end
        end else if (idx_q == CR_IDX) begin
            char_cur = 8'h0D;
        end else begin
            char_cur = 8'h0A;
        end
    end

    assign value_ready = (state_q == S_IDLE);
    assign busy        = ~value_ready;
    assign tx_ready    = (state_q == S_ISSUE) && !tx_busy;
    assign tx_send     = tx_ready ? char_cur : send_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        send_d  = send_q;
        case (state_q)
            S_IDLE: begin
                if (value_valid) begin
                    hold_d  = value;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!tx_busy) begin
                    send_d  = char_cur;
                    state_d = S_ACCEPT;
                end
            end
            // The UART raises tx_busy one cycle after the strobe, so tx_busy
            // is not trusted in this cycle.
            S_ACCEPT: state_d = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pend_d    = pend_q;
        overrun_d = overrun_q;
        if (value_ready) begin
            pend_d = 1'b0;
        end else if (value_valid) begin
            pend_d = 1'b1;
        end else if (pend_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            send_q    <= 8'h00;
            overrun_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            send_q    <= send_d;
            overrun_q <= overrun_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_hex_line_sender.sv
// tb_hex_line_sender
//   Runs three instances of hex_line_sender from shared value/value_valid
//   inputs:
//     instance 0: UPPERCASE=1, ADD_CRLF=1
//     instance 1: UPPERCASE=0, ADD_CRLF=1
//     instance 2: UPPERCASE=0, ADD_CRLF=0
//   Each instance has its own UART model. The model raises tx_busy for
//   BUSY_CYC cycles after each strobe. For instance 0, tx_busy can also be
//   forced high. Each model logs every byte it latches.
module tb_hex_line_sender;

  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        hold_busy = 1'b0;

  logic        ready_a [3];
  logic        busy_a [3];
  logic        tx_busy_a [3];
  logic [7:0]  send_a [3];
  logic        rdy_a [3];
  logic        ovr_a [3];
  logic [1:0]  dbg_a [3];
  int          cnt [3];

  logic [7:0]  log0[$];
  logic [7:0]  log1[$];
  logic [7:0]  log2[$];
  int          busy_strobes = 0;

  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    hex_line_sender #(
      .DATA_WIDTH(16),
      .ADD_CRLF  ((gi == 2) ? 0 : 1),
      .UPPERCASE ((gi == 0) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .value      (value),
      .value_valid(value_valid),
      .value_ready(ready_a[gi]),
      .tx_busy    (tx_busy_a[gi]),
      .tx_send    (send_a[gi]),
      .tx_ready   (rdy_a[gi]),
      .busy       (busy_a[gi]),
      .overrun    (ovr_a[gi]),
      .dbg_state  (dbg_a[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tx_busy_a[i] = (cnt[i] != 0) || ((i == 0) && hold_busy);
    end
  end

  // UART model: latch the byte on the strobe. Busy starts on the next cycle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rdy_a[i]) begin
          if (tx_busy_a[i]) busy_strobes <= busy_strobes + 1;
          cnt[i] <= BUSY_CYC;
          if (i == 0) log0.push_back(send_a[i]);
          if (i == 1) log1.push_back(send_a[i]);
          if (i == 2) log2.push_back(send_a[i]);
        end else if (cnt[i] != 0) begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    log0.delete();
    log1.delete();
    log2.delete();
  endtask

  // Present one request for a single cycle. The caller makes sure every
  // instance is idle first. The value then changes to garbage, which must
  // not affect the line.
  task automatic start_line(input logic [15:0] v);
    @(negedge clk);
    value = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    value = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ready_a[0] && ready_a[1] && ready_a[2]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_idle_timeout: ready=%b%b%b required all 1", name, ready_a[0], ready_a[1], ready_a[2]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++; if (ready_a[0] !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_a[0]); end
    total++; if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a[0]); end
    total++; if (rdy_a[0] !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", rdy_a[0]); end
    total++; if (send_a[0] !== 8'h00) begin bad++; $display("FAIL reset_tx_send: got %h want 00", send_a[0]); end
    total++; if (ovr_a[0] !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr_a[0]); end
    total++; if (dbg_a[0] !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_a[0]); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic test_basic_line();
    logic [7:0] exp [6];
    exp = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    clear_logs();
    start_line(16'h1A2F);
    total++; if (ready_a[0] !== 1'b0) begin bad++; $display("FAIL basic_ready_low: got %b want 0", ready_a[0]); end
    wait_idle("basic");
    total++; if (log0.size() !== 6) begin bad++; $display("FAIL basic_count: got %0d want 6", log0.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log0.size() || log0[i] !== exp[i]) begin
        bad++; $display("FAIL basic_byte%0d: got %h want %h", i, (i < log0.size()) ? log0[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (ready_a[0] !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", ready_a[0]); end
    total++; if (send_a[0] !== 8'h0A) begin bad++; $display("FAIL basic_send_hold: got %h want 0A", send_a[0]); end
  endtask

  task automatic test_case_crlf();
    logic [7:0] exp [6];
    exp = '{8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
    clear_logs();
    start_line(16'hBEEF);
    wait_idle("case");
    total++; if (log1.size() !== 6) begin bad++; $display("FAIL lower_count: got %0d want 6", log1.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log1.size() || log1[i] !== exp[i]) begin
        bad++; $display("FAIL lower_byte%0d: got %h want %h", i, (i < log1.size()) ? log1[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (log2.size() !== 4) begin bad++; $display("FAIL nocrlf_count: got %0d want 4", log2.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= log2.size() || log2[i] !== exp[i]) begin
        bad++; $display("FAIL nocrlf_byte%0d: got %h want %h", i, (i < log2.size()) ? log2[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] exp [6];
    exp = '{8'h43, 8'h30, 8'h44, 8'h45, 8'h0D, 8'h0A};
    clear_logs();
    busy_strobes = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    start_line(16'hC0DE);
    repeat (4) begin
      total++; if (rdy_a[0] !== 1'b0) begin bad++; $display("FAIL hold_no_strobe: got %b want 0", rdy_a[0]); end
      @(negedge clk);
    end
    total++; if (log0.size() !== 0) begin bad++; $display("FAIL hold_log_empty: got %0d want 0", log0.size()); end
    hold_busy = 1'b0;
    #1;
    total++; if (rdy_a[0] !== 1'b1) begin bad++; $display("FAIL hold_strobe_after_fall: got %b want 1", rdy_a[0]); end
    total++; if (send_a[0] !== 8'h43) begin bad++; $display("FAIL hold_first_byte: got %h want 43", send_a[0]); end
    @(negedge clk);
    #1;
    total++; if (rdy_a[0] !== 1'b0) begin bad++; $display("FAIL hold_single_strobe: got %b want 0", rdy_a[0]); end
    total++; if (send_a[0] !== 8'h43) begin bad++; $display("FAIL hold_send_stable: got %h want 43", send_a[0]); end
    wait_idle("hold");
    total++; if (log0.size() !== 6) begin bad++; $display("FAIL hold_count: got %0d want 6", log0.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log0.size() || log0[i] !== exp[i]) begin
        bad++; $display("FAIL hold_byte%0d: got %h want %h", i, (i < log0.size()) ? log0[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (busy_strobes !== 0) begin bad++; $display("FAIL strobe_while_busy: got %0d want 0", busy_strobes); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [6];
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    clear_logs();
    total++; if (ovr_a[0] !== 1'b0) begin bad++; $display("FAIL ovr_initial: got %b want 0", ovr_a[0]); end
    start_line(16'h1234);
    repeat (3) @(negedge clk);
    value = 16'h0001;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ovr_a[0] !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ovr_a[0]); end
    wait_idle("ovr");
    repeat (30) @(negedge clk);
    total++; if (log0.size() !== 6) begin bad++; $display("FAIL ovr_count: got %0d want 6", log0.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log0.size() || log0[i] !== exp[i]) begin
        bad++; $display("FAIL ovr_byte%0d: got %h want %h", i, (i < log0.size()) ? log0[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (ovr_a[0] !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr_a[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [12];
    int n;
    exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A,
            8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    clear_logs();
    @(negedge clk);
    value = 16'h0000;
    value_valid = 1'b1;
    @(negedge clk);
    value = 16'hFFFF;
    n = 0;
    while (!ready_a[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 2000) begin bad++; $display("FAIL b2b_timeout: got %0d cycles want <2000", n); end
    @(negedge clk);
    value_valid = 1'b0;
    wait_idle("b2b");
    total++; if (log0.size() !== 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", log0.size()); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= log0.size() || log0[i] !== exp[i]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < log0.size()) ? log0[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (ovr_a[0] !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun: got %b want 0", ovr_a[0]); end
  endtask

  task automatic test_reset_mid_line();
    logic [7:0] exp [6];
    int n;
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    clear_logs();
    start_line(16'h5678);
    n = 0;
    while (log0.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 2000) begin bad++; $display("FAIL mid_wait_timeout: got %0d cycles want <2000", n); end
    rstn = 1'b0;
    #1;
    total++; if (ready_a[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", ready_a[0]); end
    total++; if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy_a[0]); end
    total++; if (rdy_a[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_tx_ready: got %b want 0", rdy_a[0]); end
    total++; if (send_a[0] !== 8'h00) begin bad++; $display("FAIL mid_reset_tx_send: got %h want 00", send_a[0]); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (log0.size() !== 2) begin bad++; $display("FAIL mid_abandon: got %0d bytes want 2", log0.size()); end
    total++; if (log0.size() < 2 || log0[1] !== 8'h36) begin bad++; $display("FAIL mid_second_byte: got %0d bytes want byte1=36", log0.size()); end
    clear_logs();
    start_line(16'hABCD);
    wait_idle("restart");
    total++; if (log0.size() !== 6) begin bad++; $display("FAIL restart_count: got %0d want 6", log0.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log0.size() || log0[i] !== exp[i]) begin
        bad++; $display("FAIL restart_byte%0d: got %h want %h", i, (i < log0.size()) ? log0[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_case_crlf();
    test_busy_hold();
    test_overrun();
    test_reset();
    test_back_to_back();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
